// File: rtl/s38584_sel_scan_seq.sv
// s38584_sel_scan_seq
//   Upstream sequencer for the g5462/g5467 next-state cone. Walks a select
//   code across a tap vector and XOR-accumulates the armed tap bits into a
//   parity result. It keeps a two-deep history of results.
// Ports
//   CK    in   clock, rising edge
//   RST   in   asynchronous active-high reset
//   g35   in   global enable; low freezes every register
//   start in   request a scan (accepted only in IDLE)
//   abort in   return to IDLE from SCAN/DONE; q0/q1 are kept
//   arm   in   qualifies each tap bit
//   tap   in   tap bits, sampled live on each scan edge
//   sel   out  current select code
//   busy  out  state is SCAN
//   done  out  state is DONE (one enabled cycle)
//   q0    out  latest parity result (g5462 side)
//   q1    out  previous q0 (g5467 side)
module s38584_sel_scan_seq #(
   parameter int unsigned TAPS  = 16,
   parameter int unsigned SEL_W = 4
) (
   input  logic             CK,
   input  logic             RST,
   input  logic             g35,
   input  logic             start,
   input  logic             abort,
   input  logic             arm,
   input  logic [TAPS-1:0]  tap,
   output logic [SEL_W-1:0] sel,
   output logic             busy,
   output logic             done,
   output logic             q0,
   output logic             q1
);

   typedef enum logic [1:0] {StIdle, StScan, StDone} state_t;

   localparam logic [SEL_W-1:0] SelLast = SEL_W'(TAPS - 1);

   state_t           state_q, state_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic             par_q, par_d;
   logic             q0_q, q0_d;
   logic             q1_q, q1_d;
   logic             tap_bit;

   assign tap_bit = tap[sel_q] & arm;

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      par_d   = par_q;
      q0_d    = q0_q;
      q1_d    = q1_q;
      unique case (state_q)
         StIdle: begin
            // abort in IDLE blocks start on the same edge.
            if (start && !abort) begin
               state_d = StScan;
               sel_d   = '0;
               par_d   = 1'b0;
            end
         end
         StScan: begin
            if (abort) begin
               state_d = StIdle;
               sel_d   = '0;
               par_d   = 1'b0;
            end else begin
               par_d = par_q ^ tap_bit;
               if (sel_q == SelLast) begin
                  state_d = StDone;
                  sel_d   = '0;
                  q0_d    = par_q ^ tap_bit;
                  q1_d    = q0_q;
               end else begin
                  sel_d = sel_q + SEL_W'(1);
               end
            end
         end
         StDone: begin
            state_d = StIdle;
            if (abort) begin
               sel_d = '0;
               par_d = 1'b0;
            end
         end
         default: begin
            state_d = StIdle;
            sel_d   = '0;
            par_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge CK or posedge RST) begin
      if (RST) begin
         state_q <= StIdle;
         sel_q   <= '0;
         par_q   <= 1'b0;
         q0_q    <= 1'b0;
         q1_q    <= 1'b0;
      end else if (g35) begin
         state_q <= state_d;
         sel_q   <= sel_d;
         par_q   <= par_d;
         q0_q    <= q0_d;
         q1_q    <= q1_d;
      end
   end

   assign sel  = sel_q;
   assign busy = (state_q == StScan);
   assign done = (state_q == StDone);
   assign q0   = q0_q;
   assign q1   = q1_q;

endmodule
